// File: rtl/logic_axi4_stream_if.sv
// AXI4-Stream bundle shared by the stream blocks; rx is the sink view, tx the source view.
interface logic_axi4_stream_if #(
    parameter int unsigned TDATA_BYTES = 1,
    parameter int unsigned TDEST_WIDTH = 1,
    parameter int unsigned TUSER_WIDTH = 1,
    parameter int unsigned TID_WIDTH   = 1
);
    localparam int unsigned TDATA_WIDTH = 8 * TDATA_BYTES;

    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic [TDATA_BYTES-1:0] tkeep;
    logic [TDATA_BYTES-1:0] tstrb;
    logic                   tlast;
    logic [TUSER_WIDTH-1:0] tuser;
    logic [TID_WIDTH-1:0]   tid;
    logic [TDEST_WIDTH-1:0] tdest;

    modport rx (
        input  tvalid, tdata, tkeep, tstrb, tlast, tuser, tid, tdest,
        output tready
    );

    modport tx (
        output tvalid, tdata, tkeep, tstrb, tlast, tuser, tid, tdest,
        input  tready
    );
endinterface

// File: rtl/logic_reset_synchronizer.sv
// Reset synchronizer: asserts asynchronously, releases after STAGES rising edges.
module logic_reset_synchronizer #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic rst_sync_n
);
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = sync_q[STAGES-1];
endmodule

// File: rtl/logic_axi4_stream_demux.sv
// AXI4-Stream demultiplexer: routes whole packets (or single beats) from rx to tx[tdest]
// through a one-beat output stage; packets aimed past the last output are swallowed.
module logic_axi4_stream_demux #(
    parameter int unsigned OUTPUTS     = 2,
    parameter int unsigned TDATA_BYTES = 1,
    parameter int unsigned TDEST_WIDTH = 1,
    parameter int unsigned TUSER_WIDTH = 1,
    parameter int unsigned TID_WIDTH   = 1,
    parameter bit          USE_TLAST   = 1'b1,
    parameter bit          USE_TKEEP   = 1'b1,
    parameter bit          USE_TSTRB   = 1'b1
) (
    input logic             aclk,
    input logic             areset_n,
    logic_axi4_stream_if.rx rx,
    logic_axi4_stream_if.tx tx [OUTPUTS]
);
    localparam int unsigned TDATA_WIDTH = 8 * TDATA_BYTES;
    localparam int unsigned IDX_W       = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;
    localparam int unsigned IDX_N       = 1 << IDX_W;
    localparam int unsigned CMP_W       = (TDEST_WIDTH > 32) ? TDEST_WIDTH : 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PASS = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic rst_n;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] sel_q, sel_d;

    logic             stage_valid;
    logic [IDX_W-1:0] stage_idx;
    logic [TDATA_WIDTH-1:0] stage_tdata;
    logic [TDATA_BYTES-1:0] stage_tkeep;
    logic [TDATA_BYTES-1:0] stage_tstrb;
    logic                   stage_tlast;
    logic [TUSER_WIDTH-1:0] stage_tuser;
    logic [TID_WIDTH-1:0]   stage_tid;
    logic [TDEST_WIDTH-1:0] stage_tdest;

    logic [IDX_N-1:0] tready_vec_c;
    logic             stage_ready_c;
    logic             rx_ready_c;
    logic             accept_c;
    logic             beat_last_c;
    logic             dest_ok_c;
    logic             route_c;
    logic [IDX_W-1:0] route_idx_c;

    logic_reset_synchronizer #(
        .STAGES (2)
    ) u_rst_sync (
        .clk        (aclk),
        .rst_n      (areset_n),
        .rst_sync_n (rst_n)
    );

    // Per-output tready gathered into a vector so the stage target can index it.
    for (genvar k = 0; k < IDX_N; k++) begin : g_rdy
        if (k < OUTPUTS) begin : g_real
            assign tready_vec_c[k] = tx[k].tready;
        end else begin : g_pad
            assign tready_vec_c[k] = 1'b0;
        end
    end

    assign stage_ready_c = stage_valid && tready_vec_c[stage_idx];
    assign rx_ready_c    = rst_n && ((state_q == ST_DROP) || !stage_valid || stage_ready_c);
    assign rx.tready     = rx_ready_c;
    assign accept_c      = rx.tvalid && rx_ready_c;
    assign beat_last_c   = USE_TLAST ? rx.tlast : 1'b1;
    // Range check at full tdest width so e.g. tdest=4 never aliases onto output 0.
    assign dest_ok_c     = CMP_W'(rx.tdest) < CMP_W'(OUTPUTS);

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        route_c     = 1'b0;
        route_idx_c = sel_q;
        if (accept_c) begin
            case (state_q)
                ST_IDLE: begin
                    if (dest_ok_c) begin
                        route_c     = 1'b1;
                        route_idx_c = IDX_W'(rx.tdest);
                        sel_d       = IDX_W'(rx.tdest);
                        state_d     = beat_last_c ? ST_IDLE : ST_PASS;
                    end else begin
                        state_d     = beat_last_c ? ST_IDLE : ST_DROP;
                    end
                end
                ST_PASS: begin
                    route_c = 1'b1;
                    if (beat_last_c) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (beat_last_c) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Stage occupancy: a load wins over a drain so load+drain keeps it full.
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= 1'b0;
            stage_idx   <= '0;
        end else if (route_c) begin
            stage_valid <= 1'b1;
            stage_idx   <= route_idx_c;
        end else if (stage_ready_c) begin
            stage_valid <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (route_c) begin
            stage_tdata <= rx.tdata;
            stage_tkeep <= USE_TKEEP ? rx.tkeep : '1;
            stage_tstrb <= USE_TSTRB ? rx.tstrb : (USE_TKEEP ? rx.tkeep : '1);
            stage_tlast <= beat_last_c;
            stage_tuser <= rx.tuser;
            stage_tid   <= rx.tid;
            stage_tdest <= rx.tdest;
        end
    end

    for (genvar k = 0; k < OUTPUTS; k++) begin : g_tx
        assign tx[k].tvalid = stage_valid && (stage_idx == IDX_W'(k));
        assign tx[k].tdata  = stage_tdata;
        assign tx[k].tkeep  = stage_tkeep;
        assign tx[k].tstrb  = stage_tstrb;
        assign tx[k].tlast  = stage_tlast;
        assign tx[k].tuser  = stage_tuser;
        assign tx[k].tid    = stage_tid;
        assign tx[k].tdest  = stage_tdest;
    end
endmodule

// File: tb/tb_logic_axi4_stream_demux.sv
// Scoreboard bench for logic_axi4_stream_demux: directed packets, per-output expected queues.
module tb_logic_axi4_stream_demux;
    localparam int unsigned OUTPUTS     = 3;
    localparam int unsigned TDATA_BYTES = 2;
    localparam int unsigned TDEST_WIDTH = 4;
    localparam int unsigned TUSER_WIDTH = 2;
    localparam int unsigned TID_WIDTH   = 2;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  keep;
        logic [1:0]  strb;
        logic        last;
        logic [1:0]  user;
        logic [1:0]  id;
        logic [3:0]  dest;
        logic [31:0] acc;
        logic        chk;
    } exp_t;

    logic aclk = 1'b0;
    logic areset_n = 1'b0;
    always #5 aclk = ~aclk;

    logic        rx_tvalid;
    logic [15:0] rx_tdata;
    logic [1:0]  rx_tkeep, rx_tstrb, rx_tuser, rx_tid;
    logic        rx_tlast;
    logic [3:0]  rx_tdest;
    logic        rx_tready;

    logic [OUTPUTS-1:0] tx_vld, tx_rdy, tx_last;
    logic [15:0] tx_data [OUTPUTS];
    logic [1:0]  tx_keep [OUTPUTS];
    logic [1:0]  tx_strb [OUTPUTS];
    logic [1:0]  tx_user [OUTPUTS];
    logic [1:0]  tx_id   [OUTPUTS];
    logic [3:0]  tx_dest [OUTPUTS];

    logic_axi4_stream_if #(.TDATA_BYTES(TDATA_BYTES), .TDEST_WIDTH(TDEST_WIDTH),
                           .TUSER_WIDTH(TUSER_WIDTH), .TID_WIDTH(TID_WIDTH)) rx_if ();
    logic_axi4_stream_if #(.TDATA_BYTES(TDATA_BYTES), .TDEST_WIDTH(TDEST_WIDTH),
                           .TUSER_WIDTH(TUSER_WIDTH), .TID_WIDTH(TID_WIDTH)) tx_if [OUTPUTS] ();

    assign rx_if.tvalid = rx_tvalid;
    assign rx_if.tdata  = rx_tdata;
    assign rx_if.tkeep  = rx_tkeep;
    assign rx_if.tstrb  = rx_tstrb;
    assign rx_if.tlast  = rx_tlast;
    assign rx_if.tuser  = rx_tuser;
    assign rx_if.tid    = rx_tid;
    assign rx_if.tdest  = rx_tdest;
    assign rx_tready    = rx_if.tready;

    for (genvar k = 0; k < OUTPUTS; k++) begin : g_tap
        assign tx_if[k].tready = tx_rdy[k];
        assign tx_vld[k]  = tx_if[k].tvalid;
        assign tx_data[k] = tx_if[k].tdata;
        assign tx_keep[k] = tx_if[k].tkeep;
        assign tx_strb[k] = tx_if[k].tstrb;
        assign tx_last[k] = tx_if[k].tlast;
        assign tx_user[k] = tx_if[k].tuser;
        assign tx_id[k]   = tx_if[k].tid;
        assign tx_dest[k] = tx_if[k].tdest;
    end

    logic_axi4_stream_demux #(
        .OUTPUTS(OUTPUTS), .TDATA_BYTES(TDATA_BYTES), .TDEST_WIDTH(TDEST_WIDTH),
        .TUSER_WIDTH(TUSER_WIDTH), .TID_WIDTH(TID_WIDTH),
        .USE_TLAST(1'b1), .USE_TKEEP(1'b1), .USE_TSTRB(1'b1)
    ) dut (
        .aclk     (aclk),
        .areset_n (areset_n),
        .rx       (rx_if),
        .tx       (tx_if)
    );

    exp_t        exp_q [OUTPUTS][$];
    bit          seen  [OUTPUTS];
    bit          held  [OUTPUTS];
    int unsigned vecs = 0;
    int unsigned errs = 0;
    logic [31:0] cyc  = '0;

    always @(posedge aclk) cyc <= cyc + 32'd1;

    // Monitor: compares every presented beat against the head of its port queue.
    always @(negedge aclk) begin
        exp_t e;
        for (int k = 0; k < OUTPUTS; k++) begin
            if (held[k]) begin
                vecs++;
                if (!tx_vld[k]) begin
                    errs++;
                    $display("FAIL hold_valid port %0d: tvalid=0 required 1", k);
                end
            end
            held[k] = 1'b0;
            if (tx_vld[k]) begin
                vecs++;
                if (exp_q[k].size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_beat port %0d: tdata=%h tdest=%h, no beat expected",
                             k, tx_data[k], tx_dest[k]);
                end else begin
                    e = exp_q[k][0];
                    if ({tx_data[k], tx_keep[k], tx_strb[k], tx_last[k], tx_user[k], tx_id[k], tx_dest[k]} !==
                        {e.data, e.keep, e.strb, e.last, e.user, e.id, e.dest}) begin
                        errs++;
                        $display("FAIL beat port %0d: got data=%h keep=%b strb=%b last=%b user=%h id=%h dest=%h, required data=%h keep=%b strb=%b last=%b user=%h id=%h dest=%h",
                                 k, tx_data[k], tx_keep[k], tx_strb[k], tx_last[k], tx_user[k], tx_id[k], tx_dest[k],
                                 e.data, e.keep, e.strb, e.last, e.user, e.id, e.dest);
                    end
                    if (e.chk && !seen[k]) begin
                        vecs++;
                        if (cyc != e.acc) begin
                            errs++;
                            $display("FAIL latency port %0d data=%h: presented cycle %0d required %0d",
                                     k, e.data, cyc, e.acc);
                        end
                    end
                    seen[k] = 1'b1;
                    if (tx_rdy[k]) begin
                        void'(exp_q[k].pop_front());
                        seen[k] = 1'b0;
                    end else begin
                        held[k] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        rx_tvalid = 1'b0;
        repeat (n) @(posedge aclk);
        #1;
    endtask

    // Presents one beat and holds it until accepted; port<0 means the beat must be dropped.
    task automatic send(input logic [3:0] dest, input logic [15:0] data, input logic last,
                        input int port, input bit chk_rdy, input bit chk_lat);
        int   n;
        logic ok;
        exp_t e;
        rx_tvalid = 1'b1;
        rx_tdata  = data;
        rx_tkeep  = data[3:2];
        rx_tstrb  = data[5:4];
        rx_tuser  = data[7:6];
        rx_tid    = data[9:8];
        rx_tlast  = last;
        rx_tdest  = dest;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 100) begin
            @(negedge aclk);
            ok = rx_tready;
            n++;
        end
        if (!ok) begin
            vecs++;
            errs++;
            $display("FAIL accept_timeout data=%h: tready=0 for %0d cycles, required 1", data, n);
            rx_tvalid = 1'b0;
            return;
        end
        if (chk_rdy) begin
            vecs++;
            if (n != 1) begin
                errs++;
                $display("FAIL rx_tready data=%h: accepted after %0d cycles, required 1", data, n);
            end
        end
        @(posedge aclk);
        #1;
        if (port >= 0) begin
            e.data = data;       e.keep = data[3:2]; e.strb = data[5:4];
            e.last = last;       e.user = data[7:6]; e.id   = data[9:8];
            e.dest = dest;       e.acc  = cyc;       e.chk  = chk_lat;
            exp_q[port].push_back(e);
        end
    endtask

    task automatic send_pkt(input logic [3:0] dest, input int port, input int n,
                            input logic [15:0] base, input bit chk_rdy, input bit chk_lat);
        for (int i = 0; i < n; i++) begin
            send(dest, base + 16'(i * 16'h0015), (i == n - 1), port, chk_rdy, chk_lat);
        end
    endtask

    task automatic flush();
        for (int k = 0; k < OUTPUTS; k++) begin
            exp_q[k].delete();
            seen[k] = 1'b0;
            held[k] = 1'b0;
        end
    endtask

    initial begin
        rx_tvalid = 1'b0; rx_tdata = '0; rx_tkeep = '0; rx_tstrb = '0;
        rx_tuser  = '0;   rx_tid   = '0; rx_tlast = 1'b0; rx_tdest = '0;
        tx_rdy    = '1;
        flush();
        repeat (3) @(posedge aclk);
        #1;
        vecs++;
        if (rx_tready !== 1'b0) begin errs++; $display("FAIL reset_tready: got %b required 0", rx_tready); end
        vecs++;
        if (tx_vld !== '0) begin errs++; $display("FAIL reset_tvalid: got %b required 000", tx_vld); end
        areset_n = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        vecs++;
        if (rx_tready !== 1'b1) begin errs++; $display("FAIL ready_after_reset: got %b required 1", rx_tready); end

        // Route and latency: 3 beats to tx[2]
        send_pkt(4'd2, 2, 3, 16'h2100, 1'b1, 1'b1);
        idle(3);

        // Route lock: 2nd beat claims tdest=0 but stays on tx[1]
        send(4'd1, 16'h3130, 1'b0, 1, 1'b1, 1'b1);
        send(4'd0, 16'h31C4, 1'b0, 1, 1'b1, 1'b1);
        send(4'd5, 16'h3278, 1'b1, 1, 1'b1, 1'b1);
        idle(3);

        // Drop: tdest=3 packet swallowed, then tdest=0 delivered
        send_pkt(4'd3, -1, 4, 16'h4000, 1'b1, 1'b0);
        send_pkt(4'd0, 0, 2, 16'h41A0, 1'b1, 1'b1);
        idle(2);
        // Out-of-range tdest that would alias onto valid outputs if truncated
        send(4'd4, 16'h4204, 1'b1, -1, 1'b1, 1'b0);
        send(4'd8, 16'h4308, 1'b1, -1, 1'b1, 1'b0);
        send(4'hD, 16'h440D, 1'b1, -1, 1'b1, 1'b0);
        send(4'd2, 16'h45EC, 1'b1, 2, 1'b1, 1'b1);
        idle(3);

        // Backpressure: tx[1] stalls 5 cycles mid-packet
        fork
            send_pkt(4'd1, 1, 6, 16'h5000, 1'b0, 1'b0);
            begin
                repeat (2) @(posedge aclk);
                #1;
                tx_rdy[1] = 1'b0;
                repeat (2) @(negedge aclk);
                vecs++;
                if (rx_tready !== 1'b0) begin
                    errs++;
                    $display("FAIL stall_tready: got %b required 0", rx_tready);
                end
                repeat (3) @(negedge aclk);
                @(posedge aclk);
                #1;
                tx_rdy[1] = 1'b1;
            end
        join
        idle(3);

        // Back-to-back: tx[0] packet then single beat to tx[1] without a gap
        send_pkt(4'd0, 0, 3, 16'h6000, 1'b1, 1'b1);
        send(4'd1, 16'h61F0, 1'b1, 1, 1'b1, 1'b1);
        idle(3);

        // Reset mid-packet at beat 2 of 4, then a fresh packet to tx[1]
        send(4'd2, 16'h7000, 1'b0, 2, 1'b1, 1'b1);
        send(4'd2, 16'h7015, 1'b0, 2, 1'b1, 1'b1);
        #2;
        areset_n = 1'b0;
        flush();
        #1;
        vecs++;
        if (tx_vld !== '0) begin errs++; $display("FAIL async_reset_tvalid: got %b required 000", tx_vld); end
        vecs++;
        if (rx_tready !== 1'b0) begin errs++; $display("FAIL async_reset_tready: got %b required 0", rx_tready); end
        idle(2);
        areset_n = 1'b1;
        idle(3);
        send_pkt(4'd1, 1, 2, 16'h7150, 1'b1, 1'b1);
        idle(10);

        for (int k = 0; k < OUTPUTS; k++) begin
            vecs++;
            if (exp_q[k].size() != 0) begin
                errs++;
                $display("FAIL missing_beats port %0d: %0d beats never delivered, required 0", k, exp_q[k].size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", errs);
        $fatal(1);
    end
endmodule

// File: doc/logic_axi4_stream_demux.md
LOGIC_AXI4_STREAM_DEMUX -- requirements
Module: logic_axi4_stream_demux

Interface
REQ-001 SHALL have parameter OUTPUTS, default 2: number of Tx streams, at least 1.
REQ-002 SHALL have parameter TDATA_BYTES, default 1: tdata width in bytes.
REQ-003 SHALL have parameter TDEST_WIDTH, default 1: tdest width in bits; also the routing select.
REQ-004 SHALL have parameter TUSER_WIDTH, default 1: tuser width.
REQ-005 SHALL have parameter TID_WIDTH, default 1: tid width.
REQ-006 SHALL have parameter USE_TLAST, default 1: 1 means packet routing, 0 means per-beat routing.
REQ-007 SHALL have parameter USE_TKEEP, default 1: carry tkeep.
REQ-008 SHALL have parameter USE_TSTRB, default 1: carry tstrb.
REQ-009 SHALL have port aclk, input, 1 bit: single clock, rising edge.
REQ-010 SHALL have port areset_n, input, 1 bit: reset, asynchronous, active-low; internally passed through logic_reset_synchronizer before use.
REQ-011 SHALL have port rx, logic_axi4_stream_if rx modport, interface: single input stream.
REQ-012 SHALL have port tx[OUTPUTS], logic_axi4_stream_if tx modport array, interface: output streams.

Function
REQ-013 SHALL carry all enabled sideband fields unchanged to the selected output: tdata, tkeep, tstrb, tlast, tuser, tid, tdest.
REQ-014 SHALL register beats in one output stage holding one beat, target index and valid.
- Latency: a beat accepted at edge N is presented as tx[k].tvalid after edge N.
REQ-015 SHALL drive rx.tready = !stage_valid || tx[stage_idx].tready, giving 1 beat/cycle sustained throughput.
REQ-016 SHALL drive tx[k].tvalid = stage_valid && (stage_idx == k); all other outputs have tvalid 0.
REQ-017 SHALL hold tx payload stable while tx[k].tvalid=1 and tx[k].tready=0.
REQ-018 SHALL never drop tvalid once it is asserted until the handshake completes.
REQ-019 SHALL use a route FSM with states IDLE, PASS and DROP.
REQ-020 In IDLE, on an rx handshake:
- tdest < OUTPUTS: lock sel=tdest and go to PASS.
- tdest >= OUTPUTS: go to DROP.
- The same beat is routed or dropped accordingly.
REQ-021 In PASS, beats SHALL route to the locked sel regardless of the tdest of later beats; an accepted beat with tlast=1 returns the FSM to IDLE.
REQ-022 In DROP, rx.tready SHALL be 1 and beats are discarded without loading the stage; an accepted beat with tlast=1 returns the FSM to IDLE.
REQ-023 A single-beat packet (first beat has tlast=1) SHALL leave the FSM in IDLE after that beat.
REQ-024 With USE_TLAST=0, every beat SHALL be treated as tlast=1, so routing is per beat.
REQ-025 The stage SHALL load and drain in the same cycle, including when the loaded beat targets a different output than the drained beat.
REQ-026 When OUTPUTS is not a power of two, the tdest range check SHALL be done at full TDEST_WIDTH with no truncation.

Reset
REQ-027 On reset assertion, stage_valid SHALL go to 0 asynchronously, all tx[k].tvalid to 0 and the FSM to IDLE.
REQ-028 During reset, rx.tready SHALL be 0.
REQ-029 A packet in flight during reset is lost; after release, the first accepted beat is treated as a packet start.
REQ-030 Payload registers need no reset.

Verification
REQ-031 Route and latency: OUTPUTS=4, 3-beat packet with tdest=2 and all tready=1 -> tx[2] shows beats at cycles N+1..N+3 with tlast on the 3rd; tx[0,1,3] tvalid stay 0.
REQ-032 Route lock: packet tdest=1 whose 2nd beat carries tdest=0 -> all beats appear on tx[1].
REQ-033 Drop: OUTPUTS=3, packet tdest=3 of 4 beats -> rx.tready=1 throughout, no tx tvalid; the next packet tdest=0 is delivered to tx[0].
REQ-034 Backpressure: tx[1].tready=0 for 5 cycles mid-packet -> rx.tready=0 after the stage fills, payload held stable, no beat lost or duplicated.
REQ-035 Back-to-back: packet to tx[0] then single-beat packet to tx[1] with no gap -> 1 beat/cycle, destination switches on the next cycle.
REQ-036 Reset mid-packet: assert areset_n=0 at beat 2 of 4 -> all tvalid=0 immediately; after release a new packet tdest=1 routes to tx[1].
